// File: rtl/spi_ram_burst.sv
// spi_ram_burst
// Command decoder between an SPI slave's receive path and its transmit path.
// Each valid command word carries a 2-bit opcode and a DATA_WIDTH payload and
// is turned into an access to a single-port RAM of 2**ADDR_SIZE words:
//   00 SET_WR : load the write pointer from payload[ADDR_SIZE-1:0]
//   01 WRITE  : store payload at the write pointer (optional post-increment)
//   10 SET_RD : load the read pointer from payload[ADDR_SIZE-1:0]
//   11 READ   : payload L; L==0 single read, L>0 burst of L+1 words
// While a burst runs, busy is high and any command presented is discarded
// with a one-cycle drop_err pulse.
//
// Ports:
//   clk       in   clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   command word {opcode[1:0], payload[DATA_WIDTH-1:0]}
//   rx_valid  in   din holds a command this cycle
//   dout      out  read data (registered)
//   tx_valid  out  dout valid this cycle (registered)
//   busy      out  burst in progress
//   drop_err  out  one-cycle pulse: a command was dropped during a burst
//
// ADDR_SIZE must not exceed DATA_WIDTH: the address is taken from the low
// bits of the payload.

module spi_ram_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  drop_err
);

  localparam int MEM_DEPTH = 2 ** ADDR_SIZE;

  localparam logic [1:0] OP_SET_WR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RD = 2'b10;

  localparam logic [ADDR_SIZE-1:0]  ONE_A = ADDR_SIZE'(1);
  localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_SIZE-1:0]  r_wr_addr;
  logic [ADDR_SIZE-1:0]  r_rd_addr;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_tx_valid;
  logic                  r_drop_err;

  // RAM contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [1:0]            w_opcode;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [ADDR_SIZE-1:0]  w_addr;
  logic                  w_wr_en;

  assign w_opcode  = din[DATA_WIDTH+1:DATA_WIDTH];
  assign w_payload = din[DATA_WIDTH-1:0];
  assign w_addr    = din[ADDR_SIZE-1:0];

  // Writes are only honoured in IDLE; a WRITE arriving during a burst is dropped.
  assign w_wr_en = rx_valid && (r_state == S_IDLE) && (w_opcode == OP_WRITE);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_cnt      <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_drop_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            case (w_opcode)
              OP_SET_WR: r_wr_addr <= w_addr;
              OP_WRITE: begin
                if (AUTO_INC) begin
                  r_wr_addr <= r_wr_addr + ONE_A;
                end
              end
              OP_SET_RD: r_rd_addr <= w_addr;
              default: begin
                // READ: the first word is issued on the accepting edge itself.
                r_dout     <= r_mem[r_rd_addr];
                r_tx_valid <= 1'b1;
                if (w_payload != '0) begin
                  // Bursts always advance the pointer, independent of AUTO_INC.
                  r_rd_addr <= r_rd_addr + ONE_A;
                  r_cnt     <= w_payload - ONE_D;
                  r_state   <= S_BURST;
                end else if (AUTO_INC) begin
                  r_rd_addr <= r_rd_addr + ONE_A;
                end
              end
            endcase
          end
        end
        S_BURST: begin
          r_dout     <= r_mem[r_rd_addr];
          r_tx_valid <= 1'b1;
          r_rd_addr  <= r_rd_addr + ONE_A;
          // The edge that leaves BURST still drops an incoming command.
          if (rx_valid) begin
            r_drop_err <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - ONE_D;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign busy     = (r_state == S_BURST);
  assign drop_err = r_drop_err;

endmodule
